// File: rtl/dl_seq_pkg.sv
// Shared definitions for the data-latch read sequencer: FSM states,
// destination bus codes and the default wait limit.
package dl_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_RDY = 2'b01,
        ST_LATCH    = 2'b10,
        ST_DRIVE    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        DEST_DB      = 2'b00,
        DEST_ADL     = 2'b01,
        DEST_ADH     = 2'b10,
        DEST_ILLEGAL = 2'b11
    } dest_t;

    localparam int unsigned WAIT_LIMIT_DEFAULT = 15;

    // Width needed to hold 0..limit, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dl_wait_counter.sv
// Saturating RDY-low cycle counter; flags expiry on the increment that
// would make the count reach the limit.
module dl_wait_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   count_plus;

    assign count_plus = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    assign expired    = inc && (count_plus >= {1'b0, limit});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count_plus[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dl_sequencer.sv
// Sequences a memory read into reg_DL: wait for RDY, pulse LOAD, then drive
// the captured destination bus for one cycle.
module dl_sequencer
    import dl_seq_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic [1:0] REQ_DEST,
    input  logic       RDY,
    output logic       ACK,
    output logic       LOAD,
    output logic       DB_BUS_ENABLE,
    output logic       ADL_BUS_ENABLE,
    output logic       ADH_BUS_ENABLE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       TIMEOUT
);

    localparam int unsigned CNT_W = cnt_width(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    state_t state, state_next;
    dest_t  dest, dest_next;
    logic   ack_q, ack_next;
    logic   err_q, err_next;
    logic   timeout_q, timeout_next;
    logic   cnt_clear, cnt_inc, cnt_expired;

    dl_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk    (CLK),
        .rst    (RST),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .limit  (CNT_LIMIT),
        .expired(cnt_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            dest      <= DEST_DB;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            dest      <= dest_next;
            ack_q     <= ack_next;
            err_q     <= err_next;
            timeout_q <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state;
        dest_next    = dest;
        ack_next     = 1'b0;
        err_next     = 1'b0;
        timeout_next = 1'b0;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;
        case (state)
            ST_IDLE, ST_DRIVE: begin
                // DRIVE shares the IDLE accept path so a held REQ chains without a gap.
                state_next = ST_IDLE;
                if (REQ) begin
                    if (REQ_DEST != DEST_ILLEGAL) begin
                        state_next = ST_WAIT_RDY;
                        dest_next  = dest_t'(REQ_DEST);
                        ack_next   = 1'b1;
                        cnt_clear  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (RDY) begin
                    state_next = ST_LATCH;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt_expired) begin
                        state_next   = ST_IDLE;
                        timeout_next = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                state_next = ST_DRIVE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ACK            = ack_q;
        ERR            = err_q;
        TIMEOUT        = timeout_q;
        BUSY           = (state != ST_IDLE);
        LOAD           = (state == ST_LATCH);
        DONE           = (state == ST_DRIVE);
        DB_BUS_ENABLE  = (state == ST_DRIVE) && (dest == DEST_DB);
        ADL_BUS_ENABLE = (state == ST_DRIVE) && (dest == DEST_ADL);
        ADH_BUS_ENABLE = (state == ST_DRIVE) && (dest == DEST_ADH);
    end

endmodule

// File: doc/dl_sequencer.md
DL_SEQUENCER -- requirements
Module: dl_sequencer

Interface
REQ-001 The block SHALL have one parameter: WAIT_LIMIT, default 15, the maximum number of consecutive RDY-low cycles tolerated in WAIT_RDY.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 REQ  input  1  read request; the requester holds it until ACK.
REQ-005 REQ_DEST  input  2  destination bus: 00=DB, 01=ADL, 10=ADH, 11=illegal.
REQ-006 RDY  input  1  memory data valid on DATA of reg_DL.
REQ-007 ACK  output  1  one-cycle pulse; request accepted.
REQ-008 LOAD  output  1  to reg_DL LOAD.
REQ-009 DB_BUS_ENABLE, ADL_BUS_ENABLE, ADH_BUS_ENABLE  output  1 each  to the matching reg_DL enables.
REQ-010 BUSY  output  1  high in every state except IDLE.
REQ-011 DONE  output  1  one-cycle pulse; transfer delivered.
REQ-012 ERR  output  1  one-cycle pulse; illegal REQ_DEST rejected.
REQ-013 TIMEOUT  output  1  one-cycle pulse; transfer aborted on the wait limit.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_RDY, LATCH and DRIVE; all outputs SHALL be registered or decoded from registered state only.
REQ-015 IDLE: if REQ=1 with a legal destination, capture REQ_DEST, go to WAIT_RDY, and set ACK=1 for the following cycle.
REQ-016 IDLE: if REQ=1 with REQ_DEST=11, stay in IDLE, set ERR=1 for the following cycle, and leave ACK=0.
REQ-017 WAIT_RDY: if RDY=1, go to LATCH and clear the wait counter.
REQ-018 WAIT_RDY: if RDY=0, increment the wait counter; when the count reaches WAIT_LIMIT, go to IDLE, pulse TIMEOUT for the following cycle, and assert neither LOAD nor any enable.
REQ-019 LATCH: assert LOAD for exactly one cycle, then go to DRIVE.
REQ-020 DRIVE: assert only the enable selected by the captured destination for exactly one cycle, with DONE=1 in the same cycle, then go to IDLE.
REQ-021 DRIVE, back-to-back: if REQ=1 with a legal destination, go directly to WAIT_RDY with the new destination captured and ACK pulsed; an illegal destination pulses ERR and the FSM returns to IDLE.
REQ-022 REQ SHALL be ignored in WAIT_RDY and LATCH, and RDY SHALL be sampled only in WAIT_RDY.
REQ-023 Minimum latency SHALL be REQ sampled at edge k, LOAD high after edge k+1, enable high after edge k+2, with RDY already high.
REQ-024 Invariant: at most one of LOAD, DB_BUS_ENABLE, ADL_BUS_ENABLE and ADH_BUS_ENABLE SHALL be high in any cycle.
REQ-025 The wait counter SHALL be ceil(log2(WAIT_LIMIT+1)) bits wide, SHALL saturate and never wrap, and SHALL be cleared on entry to WAIT_RDY.

Reset
REQ-026 On RST=1 at a clock edge, the FSM SHALL go to IDLE, with the wait counter at 0 and the captured destination at 00.
REQ-027 During that same reset, ACK, LOAD, all enables, BUSY, DONE, ERR and TIMEOUT SHALL be 0 in the cycle following the edge.
REQ-028 A reset in any state SHALL abort the transfer with no LOAD or enable pulse afterwards; RST SHALL take priority over REQ.

Structure
REQ-029 The state encoding, destination codes (DB/ADL/ADH/illegal) and the WAIT_LIMIT default SHALL live in the shared package dl_seq_pkg.
REQ-030 The wait counter SHALL be a separate sub-module, dl_wait_counter, with inputs clear, inc and limit and output expired.

Verification
REQ-031 Basic DB transfer: REQ=1, REQ_DEST=00, RDY=1 -> ACK next cycle, LOAD one cycle later, DB_BUS_ENABLE plus DONE one cycle after that, then IDLE with BUSY=0.
REQ-032 Wait states: REQ_DEST=01, RDY low for 5 cycles then high -> LOAD occurs in the cycle after RDY rises, then ADL_BUS_ENABLE, and TIMEOUT stays 0.
REQ-033 Timeout: REQ_DEST=10, RDY held at 0 -> TIMEOUT pulses after 15 wait cycles, with no LOAD and no ADH_BUS_ENABLE; BUSY drops.
REQ-034 Illegal destination: REQ_DEST=11 -> ERR pulses once, with ACK=0 and the FSM staying in IDLE; a following REQ_DEST=00 then completes normally.
REQ-035 Back-to-back: a second REQ (dest 10) held during DRIVE of the first (dest 00) -> DB_BUS_ENABLE, then ACK, then LOAD, then ADH_BUS_ENABLE, with no IDLE cycle between.
REQ-036 Reset mid-operation: RST pulsed in LATCH -> all outputs 0 in the next cycle, no enable pulse follows, and the one-hot invariant is checked throughout all scenarios.
